// File: rtl/clock_pkg.sv
// Shared BCD definitions: digit type, largest decimal digit, and an
// integer-to-BCD helper used to build the terminal count of the counter.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam int         MAX_DIGITS    = 4;

    // Converts a non-negative integer into packed BCD, least-significant digit in [3:0]
    function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int value);
        logic [4*MAX_DIGITS-1:0] result;
        int                      remaining;
        result    = '0;
        remaining = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            result[4*i +: 4] = bcd_digit_t'(remaining % 10);
            remaining        = remaining / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of next-value logic for an up/down BCD chain.
// The digit steps when its carry-in is set and ripples a carry/borrow onward;
// when the whole counter wraps, every digit loads its wrap value instead.
module bcd_digit
    import clock_pkg::*;
(
    input  logic       up,
    input  logic       cin,
    input  logic       wrap,
    input  logic [3:0] wrap_val,
    input  logic [3:0] d,
    output logic [3:0] nxt,
    output logic       cout
);

    // Next digit value: global wrap overrides, otherwise step with decimal carry/borrow
    always_comb begin
        nxt  = d;
        cout = 1'b0;
        if (wrap) begin
            nxt = wrap_val;
        end else if (cin) begin
            if (up) begin
                if (d >= BCD_MAX_DIGIT) begin
                    nxt  = 4'd0;
                    cout = 1'b1;
                end else begin
                    nxt = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    nxt  = BCD_MAX_DIGIT;
                    cout = 1'b1;
                end else begin
                    nxt = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Up/down BCD counter over 0..MODULUS-1 built from a chain of bcd_digit cells.
// tc is combinational for same-cycle cascading; co is a registered wrap pulse.
// Optional feature macro: BCD_MOD_COUNTER_LOAD_EN adds a synchronous preset
// (load, load_val) with a registered invalid-preset pulse (load_err).
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
`ifdef BCD_MOD_COUNTER_LOAD_EN
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic                  load_err,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  co
);

    localparam int                      W        = 4 * DIGITS;
    localparam logic [4*MAX_DIGITS-1:0] MAX_FULL = int_to_bcd(MODULUS - 1);
    localparam logic [W-1:0]            MAX_BCD  = MAX_FULL[W-1:0];

    // A value is canonical when every digit is decimal and it lies below MODULUS;
    // with decimal digits, plain unsigned comparison matches numeric order.
    function automatic logic is_canonical(input logic [W-1:0] v);
        logic ok;
        ok = (v <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > BCD_MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    logic          q_ok;
    logic          wrap_hit;
    logic [W-1:0]  q_next;
    logic [DIGITS:0] carry;

    assign q_ok     = is_canonical(q);
    assign wrap_hit = (up && (q == MAX_BCD)) || (!up && (q == '0));
    assign tc       = en & wrap_hit;
    assign carry[0] = 1'b1;

    // Digit chain: the least-significant digit always steps, higher digits follow its carry
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .up       (up),
            .cin      (carry[i]),
            .wrap     (wrap_hit),
            .wrap_val (up ? 4'd0 : MAX_BCD[4*i +: 4]),
            .d        (q[4*i +: 4]),
            .nxt      (q_next[4*i +: 4]),
            .cout     (carry[i+1])
        );
    end

`ifdef BCD_MOD_COUNTER_LOAD_EN
    logic load_ok;
    assign load_ok = is_canonical(load_val);
`endif

    // Count register: preset wins over counting; a corrupt or overflowing count is cleared silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q  <= '0;
            co <= 1'b0;
`ifdef BCD_MOD_COUNTER_LOAD_EN
            load_err <= 1'b0;
`endif
        end else begin
            co <= 1'b0;
`ifdef BCD_MOD_COUNTER_LOAD_EN
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    q <= load_val;
                end else begin
                    load_err <= 1'b1;
                end
            end else
`endif
            if (en) begin
                if (!q_ok || carry[DIGITS]) begin
                    q <= '0;
                end else begin
                    q  <= q_next;
                    co <= wrap_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: a driver pushes expected q/co/load_err
// per clock edge, a monitor pops and compares after each rising edge.
// Instance a uses default parameters, instance b uses MODULUS=24.
module tb_bcd_mod_counter;

    typedef struct {
        bit         sel;
        logic [7:0] q;
        logic       co;
        logic       err;
        int         step;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en_a, up_a, en_b, up_b;
    logic [7:0] q_a, q_b;
    logic       tc_a, tc_b, co_a, co_b;
`ifdef BCD_MOD_COUNTER_LOAD_EN
    logic       load_a;
    logic [7:0] load_val_a;
    logic       load_err_a, load_err_b;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    bcd_mod_counter dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en_a),
        .up       (up_a),
`ifdef BCD_MOD_COUNTER_LOAD_EN
        .load     (load_a),
        .load_val (load_val_a),
        .load_err (load_err_a),
`endif
        .q        (q_a),
        .tc       (tc_a),
        .co       (co_a)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en_b),
        .up       (up_b),
`ifdef BCD_MOD_COUNTER_LOAD_EN
        .load     (1'b0),
        .load_val (8'h00),
        .load_err (load_err_b),
`endif
        .q        (q_b),
        .tc       (tc_b),
        .co       (co_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] toBcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %h expected %h", name, step, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic e, input logic u,
                                 input logic ld, input logic [7:0] lv,
                                 input logic [7:0] exp_q, input logic exp_co, input logic exp_err,
                                 input bit chk_tc, input logic exp_tc);
        exp_t item;
        @(negedge clk);
        if (sel) begin
            en_b = e;
            up_b = u;
            en_a = 1'b0;
        end else begin
            en_a = e;
            up_a = u;
            en_b = 1'b0;
        end
`ifdef BCD_MOD_COUNTER_LOAD_EN
        load_a     = ld;
        load_val_a = lv;
`else
        if (ld) $display("[TB] note: preset step %0d value %h without preset ports", step, lv);
`endif
        step++;
        item.sel  = sel;
        item.q    = exp_q;
        item.co   = exp_co;
        item.err  = exp_err;
        item.step = step;
        sb.push_back(item);
        #1;
        if (chk_tc) checkOutput("tc", 8'(sel ? tc_b : tc_a), 8'(exp_tc));
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest expectation
    initial begin
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                item = sb.pop_front();
                if (item.sel) begin
                    checkOutput("q_b", q_b, item.q);
                    checkOutput("co_b", 8'(co_b), 8'(item.co));
`ifdef BCD_MOD_COUNTER_LOAD_EN
                    checkOutput("load_err_b", 8'(load_err_b), 8'(item.err));
`endif
                end else begin
                    checkOutput("q_a", q_a, item.q);
                    checkOutput("co_a", 8'(co_a), 8'(item.co));
`ifdef BCD_MOD_COUNTER_LOAD_EN
                    checkOutput("load_err_a", 8'(load_err_a), 8'(item.err));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst  = 1'b0;
        en_a = 1'b0;
        up_a = 1'b1;
        en_b = 1'b0;
        up_b = 1'b1;
`ifdef BCD_MOD_COUNTER_LOAD_EN
        load_a     = 1'b0;
        load_val_a = 8'h00;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset q_a", q_a, 8'h00);
        checkOutput("reset co_a", 8'(co_a), 8'h00);
        checkOutput("reset q_b", q_b, 8'h00);
`ifdef BCD_MOD_COUNTER_LOAD_EN
        checkOutput("reset load_err_a", 8'(load_err_a), 8'h00);
`endif
        rst = 1'b1;

        // Full up-count through the wrap, then one more step
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, toBcd(k % 60), (k == 60), 1'b0, 1'b1, (k == 60));
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);

        // Down wrap and direction changes without dead cycles
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h59, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h58, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h59, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 1'b0, 1'b0, 1'b1, 1'b0);

        // Count down to 0x37
        for (int k = 1; k <= 22; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, toBcd(59 - k), 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset between edges with a count pending
        @(negedge clk);
        en_a = 1'b1;
        up_a = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset q_a", q_a, 8'h00);
        checkOutput("async reset co_a", 8'(co_a), 8'h00);
        @(negedge clk);
        rst  = 1'b1;
        en_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef BCD_MOD_COUNTER_LOAD_EN
        // Presets: valid, bad digit, out of range, and priority over a pending wrap
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h45, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h4A, 8'h45, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h60, 8'h45, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h59, 1'b1, 1'b0, 1'b1, 1'b1);
`endif

        // Modulus-24 instance: full up-count, then down wrap to 0x23
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, toBcd(k % 24), (k == 24), 1'b0, 1'b1, (k == 24));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h23, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
